// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, default latencies and decode helpers shared by the MDU and the decoder
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_div_op(input logic [3:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction

    function automatic logic is_long_op(input logic [3:0] op);
        return is_div_op(op) || op == OP_MULT || op == OP_MULTU ||
               (op >= OP_MADD && op <= OP_MSUBU);
    endfunction

endpackage

// File: rtl/mdu.sv
// mdu: HI/LO multiply-divide unit with fixed-latency commit of a precomputed result
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [31:0]   hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, sdiv;
    logic [63:0]   acc, prod_s, prod_u, res;
    logic [31:0]   dvd, dvs, uq, ur, sq, sr;

    assign busy   = cnt_q != '0;
    assign accept = start && !busy;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign out    = op == OP_MFHI ? hi_q : op == OP_MFLO ? lo_q : 32'd0;

    // Full result of the offered op, computed before it is parked in the pending registers
    always_comb begin
        acc    = {hi_q, lo_q};
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};
        sdiv   = op == OP_DIV;
        dvd    = sdiv && a[31] ? -a : a;
        dvs    = b == 32'd0 ? 32'd1 : sdiv && b[31] ? -b : b;
        uq     = dvd / dvs;
        ur     = dvd % dvs;
        sq     = sdiv && (a[31] ^ b[31]) ? -uq : uq;
        sr     = sdiv && a[31] ? -ur : ur;
        res    = op == OP_MULT  ? prod_s :
                 op == OP_MULTU ? prod_u :
                 op == OP_MADD  ? acc + prod_s :
                 op == OP_MADDU ? acc + prod_u :
                 op == OP_MSUB  ? acc - prod_s :
                 op == OP_MSUBU ? acc - prod_u :
                 b == 32'd0     ? acc : {sr, sq};
    end

    // Next state: commit on the last busy cycle, launch or move-to on an accepted op
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        phi_d = phi_q;
        plo_d = plo_q;
        cnt_d = busy ? cnt_q - CW'(1) : cnt_q;
        if (cnt_q == CW'(1)) begin
            hi_d = phi_q;
            lo_d = plo_q;
        end
        if (accept && is_long_op(op)) begin
            {phi_d, plo_d} = res;
            cnt_d          = is_div_op(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
        if (accept && op == OP_MTHI) hi_d = a;
        if (accept && op == OP_MTLO) lo_d = a;
    end

    // State registers; reset drops any in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            phi_q <= '0;
            plo_q <= '0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed and randomized checks of the MDU against a commit-time reference model
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo, out;

    int vectors = 0, miscompares = 0;

    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;
    bit          m_busy = 1'b0;
    int          edge_n = 0, m_done = 0;

    always #5 clk = ~clk;

    mdu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo), .out(out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] acc);
        longint sx = $signed(x);
        longint sy = $signed(y);
        logic [63:0] sp = 64'(sx * sy);
        logic [63:0] up = 64'(x) * 64'(y);
        int si = $signed(x);
        int sj = $signed(y);
        case (o)
            OP_MULT:  return sp;
            OP_MULTU: return up;
            OP_MADD:  return acc + sp;
            OP_MADDU: return acc + up;
            OP_MSUB:  return acc - sp;
            OP_MSUBU: return acc - up;
            OP_DIV: begin
                if (y == 0) return acc;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(si % sj), 32'(si / sj)};
            end
            default: return y == 0 ? acc : {x % y, x / y};
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
        chk({tag, ".out"}, out, op == OP_MFHI ? m_hi : op == OP_MFLO ? m_lo : 32'd0);
    endtask

    task automatic step(input string tag);
        bit was_busy;
        @(posedge clk);
        edge_n++;
        if (rst_n) begin
            was_busy = m_busy;
            if (m_busy && edge_n == m_done) begin
                {m_hi, m_lo} = m_pend;
                m_busy = 1'b0;
            end
            if (!was_busy && start) begin
                if (is_long_op(op)) begin
                    m_pend = ref_result(op, a, b, {m_hi, m_lo});
                    m_busy = 1'b1;
                    m_done = edge_n + (is_div_op(op) ? DIV_CYCLES_DEF : MULT_CYCLES_DEF);
                end
                if (op == OP_MTHI) m_hi = a;
                if (op == OP_MTLO) m_lo = a;
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic drive(input logic s, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input string tag);
        start = s; op = o; a = x; b = y;
        step(tag);
    endtask

    task automatic wait_idle(input logic [3:0] o, output int n);
        n = 0;
        while (busy && n < 40) begin
            drive(1'b0, o, 32'd0, 32'd0, "wait");
            n++;
        end
    endtask

    int n;
    logic [31:0] old_hi, ra, rb;

    initial begin
        repeat (2) @(negedge clk);
        op = OP_MFHI;
        check_outputs("reset");
        rst_n = 1'b1;

        drive(1, OP_MULT, 32'hFFFFFFFF, 32'd2, "mult");
        wait_idle(OP_NONE, n);
        chk("mult_lat", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);

        drive(1, OP_MULTU, 32'hFFFFFFFF, 32'd2, "multu");
        wait_idle(OP_NONE, n);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        drive(1, OP_DIV, 32'hFFFFFFF9, 32'd2, "div");
        wait_idle(OP_NONE, n);
        chk("div_lat", 32'(n), 32'd10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        drive(1, OP_DIVU, 32'd7, 32'd0, "divu0");
        wait_idle(OP_NONE, n);
        chk("divu0_lat", 32'(n), 32'd10);
        chk("divu0_hi", hi, 32'hFFFFFFFF);
        chk("divu0_lo", lo, 32'hFFFFFFFD);

        drive(1, OP_DIV, 32'h80000000, 32'hFFFFFFFF, "divovf");
        wait_idle(OP_NONE, n);
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'h0);

        drive(1, OP_MTHI, 32'd0, 32'd0, "mthi");
        chk("mthi_busy", 32'(busy), 32'd0);
        drive(1, OP_MTLO, 32'hFFFFFFFF, 32'd0, "mtlo");
        drive(1, OP_MADD, 32'd1, 32'd1, "madd");
        wait_idle(OP_NONE, n);
        chk("madd_hi", hi, 32'd1);
        chk("madd_lo", lo, 32'd0);

        drive(1, OP_MTHI, 32'd0, 32'd0, "mthi");
        drive(1, OP_MTLO, 32'd0, 32'd0, "mtlo");
        drive(1, OP_MSUB, 32'd1, 32'd1, "msub");
        wait_idle(OP_NONE, n);
        chk("msub_hi", hi, 32'hFFFFFFFF);
        chk("msub_lo", lo, 32'hFFFFFFFF);

        drive(1, OP_DIV, 32'd100, 32'd7, "divbusy");
        drive(1, OP_MULT, 32'd3, 32'd3, "multign");
        wait_idle(OP_MFHI, n);
        chk("busy_ext", 32'(n + 1), 32'd10);
        chk("divbusy_hi", hi, 32'd2);
        chk("divbusy_lo", lo, 32'd14);

        old_hi = hi;
        drive(1, OP_MULTU, 32'h10000, 32'h10000, "mfhi_launch");
        drive(1, OP_MFHI, 32'd0, 32'd0, "mfhi_busy");
        chk("mfhi_old", out, old_hi);
        wait_idle(OP_MFHI, n);
        chk("mfhi_new", out, 32'd1);

        drive(1, OP_DIVU, 32'd50, 32'd3, "divrst");
        drive(0, OP_NONE, 32'd0, 32'd0, "divrst");
        rst_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0; m_busy = 1'b0;
        check_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) drive(0, OP_MFLO, 32'd0, 32'd0, "post_rst");

        for (int i = 0; i < 1500; i++) begin
            ra = $urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom;
            rb = $urandom_range(0, 4) == 0 ? ($urandom_range(0, 1) ? 32'd0 : 32'hFFFFFFFF) : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'hF;
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), ra, rb, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
